// File: rtl/coin_display_pkg.sv
// Shared definitions for the coin credit display: segment patterns (active-low
// {g,f,e,d,c,b,a}), converter state encoding and the digit-to-segment decoder.
package coin_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/coin_display_if.sv
// Credit/flag inputs and multiplexed 7-segment outputs of the coin display.
// master = credit source and display consumer, slave = coin_display itself.
interface coin_display_if #(
    parameter int VAL_W = 10
);
    logic [VAL_W-1:0] coin_val;
    logic             buy_flag;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             dp;
    logic             conv_busy;

    modport master (
        output coin_val, buy_flag,
        input  an, seg, dp, conv_busy
    );

    modport slave (
        input  coin_val, buy_flag,
        output an, seg, dp, conv_busy
    );
endinterface

// File: rtl/coin_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter, one bit per clock.
// busy covers the SHIFT and DONE states; done marks the cycle bcd is final.
module bin2bcd_seq
    import coin_display_pkg::*;
#(
    parameter int VAL_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);
    localparam int CNT_W = $clog2(VAL_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VAL_W - 1);

    conv_state_t      state_reg;
    logic [VAL_W-1:0] shift_reg;
    logic [15:0]      bcd_reg;
    logic [15:0]      bcd_adj;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic             busy_reg;

    // Each nibble is corrected before the shift so it never exceeds 9 after doubling.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg   <= bin;
                        bcd_reg     <= '0;
                        bit_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_reg     <= (bcd_adj << 1) | 16'(shift_reg[VAL_W-1]);
                    shift_reg   <= shift_reg << 1;
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == LAST_BIT)
                        state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = (state_reg == ST_DONE);
    assign bcd  = bcd_reg;

endmodule

// File: rtl/coin_display.sv
// Shows the synchronised credit as up to four decimal digits on a scanned
// 7-segment display; the units decimal point reflects the purchase flag.
module coin_display #(
    parameter int SCAN_DIV = 100_000,
    parameter int VAL_W    = 10
) (
    input  logic          clk,
    input  logic          reset,
    coin_display_if.slave bus
);
    import coin_display_pkg::*;

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    logic [VAL_W-1:0] val_meta_reg, val_sync_reg, snap_reg;
    logic             buy_meta_reg, buy_sync_reg;
    logic             conv_start, conv_busy, conv_done;
    logic [15:0]      conv_bcd, shown_reg;
    logic [CNT_W-1:0] scan_cnt_reg;
    logic [1:0]       digit_idx_reg;
    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [3:0]       digit_lit;
    logic [6:0]       digit_seg [4];

    // A new conversion is only accepted while the converter is idle (busy low).
    assign conv_start = !conv_busy && (val_sync_reg != snap_reg);

    bin2bcd_seq #(.VAL_W(VAL_W)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (val_sync_reg),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Leading-zero blanking: a digit lights if it or any higher digit is non-zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            if (gi == 0) begin : g_units
                assign digit_lit[gi] = 1'b1;
            end else begin : g_upper
                assign digit_lit[gi] = |shown_reg[15:gi*4];
            end
            assign digit_seg[gi] = digit_lit[gi] ? seg_decode(shown_reg[gi*4 +: 4]) : SEG_BLANK;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val_meta_reg  <= '0;
            val_sync_reg  <= '0;
            buy_meta_reg  <= 1'b0;
            buy_sync_reg  <= 1'b0;
            snap_reg      <= '0;
            shown_reg     <= '0;
            scan_cnt_reg  <= '0;
            digit_idx_reg <= 2'd0;
            an_reg        <= 4'hF;
            seg_reg       <= SEG_BLANK;
            dp_reg        <= 1'b1;
        end else begin
            val_meta_reg <= bus.coin_val;
            val_sync_reg <= val_meta_reg;
            buy_meta_reg <= bus.buy_flag;
            buy_sync_reg <= buy_meta_reg;

            if (conv_start)
                snap_reg <= val_sync_reg;
            if (conv_done)
                shown_reg <= conv_bcd;

            if (scan_cnt_reg == SCAN_LAST) begin
                scan_cnt_reg  <= '0;
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end

            an_reg  <= ~(4'b0001 << digit_idx_reg);
            seg_reg <= digit_seg[digit_idx_reg];
            dp_reg  <= !((digit_idx_reg == 2'd0) && buy_sync_reg);
        end
    end

    assign bus.an        = an_reg;
    assign bus.seg       = seg_reg;
    assign bus.dp        = dp_reg;
    assign bus.conv_busy = conv_busy;

endmodule
